payload_rd_arbiter: RTL and testbench

Parametrised multi-channel front end for PayloadBuffer read transactions. Connects NUM_CH independent read clients to the single PayloadBuffer read port. Arbitrates round-robin, runs one complete chain read at a time (address phase, then block burst until the last block), and steers the returned blocks to the granted client. Adds what the bare read bus lacks: an explicit enable, per-client request handshake, back-to-back chaining and a runaway-chain watchdog.

---
 rtl/payload_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_payload_rd_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_rd_arbiter.sv
// Round-robin front end that shares the PayloadBuffer read port among NUM_CH clients,
// one chain read at a time, with back-to-back chaining and a runaway-chain watchdog.
//
// state | meaning
// IDLE  | no chain active; arbitrate any pending request
// ADDR  | address phase on the read port (pb_is_first=1)
// BURST | blocks returned to the granted client until last block or watchdog
module payload_rd_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int BCNT_W     = 4,
    parameter int MAX_BLOCKS = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_req_valid,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_address,
    input  logic [NUM_CH-1:0]          ch_req_destructive,
    output logic [NUM_CH-1:0]          ch_req_ready,
    output logic [NUM_CH-1:0]          ch_rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [BCNT_W-1:0]          rsp_byte_count,
    output logic                       rsp_is_last,
    output logic                       rsp_error,
    output logic                       pb_enable,
    output logic                       pb_is_first,
    output logic [ADDR_W-1:0]          pb_address,
    output logic                       pb_is_destructive,
    input  logic                       pb_valid,
    input  logic [DATA_W-1:0]          pb_data,
    input  logic [BCNT_W-1:0]          pb_byte_count,
    input  logic                       pb_is_last
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    grant_q;
    logic [CH_W-1:0]    rr_ptr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               destr_q;
    logic [CNT_W-1:0]   blk_cnt_q;
    logic               pb_enable_q;
    logic               pb_is_first_q;

    logic               in_burst;
    logic               blk_valid;
    logic               wd_hit;
    logic               chain_end;
    logic [CH_W-1:0]    arb_base;
    logic               arb_found;
    logic [CH_W-1:0]    arb_idx;
    logic               do_grant;
    logic [ADDR_W-1:0]  sel_addr;

    assign in_burst  = (state_q == S_BURST);
    assign blk_valid = in_burst && pb_valid;
    assign wd_hit    = !pb_is_last && (blk_cnt_q == CNT_W'(MAX_BLOCKS - 1));
    assign chain_end = blk_valid && (pb_is_last || wd_hit);

    // At end of chain the pointer is about to become grant_q, so search from there already.
    assign arb_base = in_burst ? grant_q : rr_ptr_q;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int unsigned cand;
            cand = (int'(arb_base) + k) % NUM_CH;
            if (!arb_found && ch_req_valid[CH_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = CH_W'(cand);
            end
        end
    end

    assign do_grant = arb_found && ((state_q == S_IDLE) || chain_end);
    assign sel_addr = ch_req_address[arb_idx*ADDR_W +: ADDR_W];

    always_comb begin
        state_d      = state_q;
        ch_req_ready = '0;
        if (do_grant) begin
            ch_req_ready[arb_idx] = 1'b1;
        end
        case (state_q)
            S_IDLE:  if (arb_found) state_d = S_ADDR;
            S_ADDR:  state_d = S_BURST;
            S_BURST: if (chain_end) state_d = arb_found ? S_ADDR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= CH_W'(NUM_CH - 1);
            addr_q        <= '0;
            destr_q       <= 1'b0;
            blk_cnt_q     <= '0;
            pb_enable_q   <= 1'b0;
            pb_is_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pb_enable_q   <= (state_d != S_IDLE);
            pb_is_first_q <= (state_d == S_ADDR);
            if (do_grant) begin
                grant_q <= arb_idx;
                addr_q  <= sel_addr;
                destr_q <= ch_req_destructive[arb_idx];
            end
            if (chain_end) begin
                rr_ptr_q <= grant_q;
            end
            if (state_q == S_ADDR) begin
                blk_cnt_q <= '0;
            end else if (blk_valid) begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ch_rsp_valid          = '0;
        ch_rsp_valid[grant_q] = blk_valid;
    end

    assign rsp_data          = in_burst ? pb_data : '0;
    assign rsp_byte_count    = in_burst ? pb_byte_count : '0;
    assign rsp_is_last       = in_burst && pb_is_last;
    assign rsp_error         = blk_valid && wd_hit;
    assign pb_enable         = pb_enable_q;
    assign pb_is_first       = pb_is_first_q;
    assign pb_address        = addr_q;
    assign pb_is_destructive = destr_q;

endmodule

// File: tb/tb_payload_rd_arbiter.sv
// Scoreboard bench for payload_rd_arbiter: directed chains push expected grants,
// address phases and responses; a negedge monitor pops and compares them.
module tb_payload_rd_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int BCNT_W = 4;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_CH-1:0]         ch_req_valid;
    logic [NUM_CH*ADDR_W-1:0]  ch_req_address;
    logic [NUM_CH-1:0]         ch_req_destructive;
    logic [NUM_CH-1:0]         ch_req_ready;
    logic [NUM_CH-1:0]         ch_rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [BCNT_W-1:0]         rsp_byte_count;
    logic                      rsp_is_last;
    logic                      rsp_error;
    logic                      pb_enable;
    logic                      pb_is_first;
    logic [ADDR_W-1:0]         pb_address;
    logic                      pb_is_destructive;
    logic                      pb_valid;
    logic [DATA_W-1:0]         pb_data;
    logic [BCNT_W-1:0]         pb_byte_count;
    logic                      pb_is_last;

    payload_rd_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BCNT_W(BCNT_W), .MAX_BLOCKS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ch_req_valid(ch_req_valid), .ch_req_address(ch_req_address),
        .ch_req_destructive(ch_req_destructive), .ch_req_ready(ch_req_ready),
        .ch_rsp_valid(ch_rsp_valid), .rsp_data(rsp_data),
        .rsp_byte_count(rsp_byte_count), .rsp_is_last(rsp_is_last),
        .rsp_error(rsp_error), .pb_enable(pb_enable), .pb_is_first(pb_is_first),
        .pb_address(pb_address), .pb_is_destructive(pb_is_destructive),
        .pb_valid(pb_valid), .pb_data(pb_data), .pb_byte_count(pb_byte_count),
        .pb_is_last(pb_is_last)
    );

    typedef struct {
        int               ch;
        logic [DATA_W-1:0] data;
        logic [BCNT_W-1:0] bcnt;
        logic             last;
        logic             err;
    } rsp_t;

    int              gq[$];
    logic [ADDR_W:0] aq[$];
    rsp_t            rq[$];
    int              checks = 0;
    int              errors = 0;
    int              rsp_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input int ch, input logic [DATA_W-1:0] d, input logic [BCNT_W-1:0] b,
                       input logic last, input logic err);
        rsp_t r;
        pb_valid = 1'b1;
        pb_data = d;
        pb_byte_count = b;
        pb_is_last = last;
        r.ch = ch; r.data = d; r.bcnt = b; r.last = last; r.err = err;
        rq.push_back(r);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ch_req_ready != '0) begin
                if (gq.size() == 0) check("grant_unexpected", 64'(ch_req_ready), 64'd0);
                else check("grant", 64'(ch_req_ready), 64'(1) << gq.pop_front());
            end
            if (pb_is_first) begin
                if (aq.size() == 0) check("addr_unexpected", 64'(pb_is_first), 64'd0);
                else check("addr_phase", 64'({pb_address, pb_is_destructive}), 64'(aq.pop_front()));
            end
            if (ch_rsp_valid != '0) begin
                rsp_seen++;
                if (rq.size() == 0) check("rsp_unexpected", 64'(ch_rsp_valid), 64'd0);
                else begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rsp_ch", 64'(ch_rsp_valid), 64'(1) << r.ch);
                    check("rsp_data", rsp_data, r.data);
                    check("rsp_bcnt", 64'(rsp_byte_count), 64'(r.bcnt));
                    check("rsp_last", 64'(rsp_is_last), 64'(r.last));
                    check("rsp_err", 64'(rsp_error), 64'(r.err));
                end
            end
        end
    end

    initial begin
        int seen0;
        reset_n = 1'b0;
        ch_req_valid = '0;
        ch_req_address = '0;
        ch_req_destructive = '0;
        pb_valid = 1'b0;
        pb_data = '0;
        pb_byte_count = '0;
        pb_is_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", 64'(pb_enable), 64'd0);
        check("rst_first", 64'(pb_is_first), 64'd0);
        check("rst_addr", 64'(pb_address), 64'd0);
        check("rst_destr", 64'(pb_is_destructive), 64'd0);
        check("rst_ready", 64'(ch_req_ready), 64'd0);
        reset_n = 1'b1;
        tick;

        // Fairness: all channels request continuously, one-block chains.
        for (int i = 0; i < NUM_CH; i++) begin
            ch_req_address[i*ADDR_W +: ADDR_W] = ADDR_W'(12'h100 + i);
            ch_req_destructive[i] = i[0];
        end
        for (int g = 0; g < 5; g++) begin
            rsp_t r;
            gq.push_back(g % NUM_CH);
            aq.push_back({ADDR_W'(12'h100 + (g % NUM_CH)), 1'((g % NUM_CH) & 1)});
            r.ch = g % NUM_CH; r.data = 64'hFA1A_0000; r.bcnt = 4'd4; r.last = 1'b1; r.err = 1'b0;
            rq.push_back(r);
        end
        ch_req_valid = '1;
        pb_valid = 1'b1; pb_data = 64'hFA1A_0000; pb_byte_count = 4'd4; pb_is_last = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 9) ch_req_valid = '0;
            @(negedge clk);
            check($sformatf("fair_enable_c%0d", c), 64'(pb_enable), 64'(c >= 1));
            check($sformatf("fair_first_c%0d", c), 64'(pb_is_first), 64'(c % 2));
            tick;
        end
        pb_valid = 1'b0; pb_is_last = 1'b0;
        @(negedge clk);
        check("fair_idle_after", 64'(pb_enable), 64'd0);
        tick;

        // Single request: ch1, addr 0x05, destructive, 3 blocks.
        gq.push_back(1);
        aq.push_back({10'h005, 1'b1});
        ch_req_address[1*ADDR_W +: ADDR_W] = 10'h005;
        ch_req_destructive = 4'b0010;
        ch_req_valid = 4'b0010;
        tick;
        ch_req_valid = '0;
        @(negedge clk);
        check("t1_first_c1", 64'(pb_is_first), 64'd1);
        tick; blk(1, 64'hA1A1_0001, 4'd8, 1'b0, 1'b0);
        tick; blk(1, 64'hA1A1_0002, 4'd8, 1'b0, 1'b0);
        tick; blk(1, 64'hA1A1_0003, 4'd5, 1'b1, 1'b0);
        tick; pb_valid = 1'b0; pb_is_last = 1'b0;
        @(negedge clk);
        check("t1_enable_c5", 64'(pb_enable), 64'd0);
        tick;

        // Stalled slave: ch2, 2 blocks, 3 empty cycles between.
        gq.push_back(2);
        aq.push_back({10'h3AA, 1'b0});
        ch_req_address[2*ADDR_W +: ADDR_W] = 10'h3AA;
        ch_req_destructive = '0;
        ch_req_valid = 4'b0100;
        seen0 = rsp_seen;
        tick; ch_req_valid = '0;
        tick; blk(2, 64'h5757_0001, 4'd8, 1'b0, 1'b0);
        tick; pb_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_enable_%0d", c), 64'(pb_enable), 64'd1);
            check($sformatf("stall_norsp_%0d", c), 64'(ch_rsp_valid), 64'd0);
            tick;
        end
        blk(2, 64'h5757_0002, 4'd3, 1'b1, 1'b0);
        tick; pb_valid = 1'b0; pb_is_last = 1'b0;
        @(negedge clk);
        check("stall_rsp_count", 64'(rsp_seen - seen0), 64'd2);
        check("stall_idle", 64'(pb_enable), 64'd0);
        tick;

        // Watchdog: ch3, slave never signals last; MAX_BLOCKS=4.
        gq.push_back(3);
        aq.push_back({10'h02F, 1'b1});
        ch_req_address[3*ADDR_W +: ADDR_W] = 10'h02F;
        ch_req_destructive = 4'b1000;
        ch_req_valid = 4'b1000;
        tick; ch_req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            tick; blk(3, 64'hD06_0000 + 64'(b), 4'd8, 1'b0, 1'(b == 3));
        end
        tick; pb_valid = 1'b0;
        @(negedge clk);
        check("wd_idle_enable", 64'(pb_enable), 64'd0);
        check("wd_idle_first", 64'(pb_is_first), 64'd0);
        tick;

        // Stray data in IDLE and ADDR must be ignored.
        pb_valid = 1'b1; pb_data = 64'h57A7; pb_byte_count = 4'd2; pb_is_last = 1'b1;
        @(negedge clk);
        check("stray_idle", 64'(ch_rsp_valid), 64'd0);
        tick;
        gq.push_back(0);
        aq.push_back({10'h1C3, 1'b0});
        ch_req_address[0 +: ADDR_W] = 10'h1C3;
        ch_req_destructive = '0;
        ch_req_valid = 4'b0001;
        @(negedge clk);
        check("stray_idle_req", 64'(ch_rsp_valid), 64'd0);
        tick; ch_req_valid = '0;
        @(negedge clk);
        check("stray_addr", 64'(ch_rsp_valid), 64'd0);
        tick; blk(0, 64'h57A7, 4'd2, 1'b1, 1'b0);
        tick; pb_valid = 1'b0; pb_is_last = 1'b0;
        tick;

        // Reset during BURST on the 2nd block, then ch0 must win first.
        gq.push_back(1);
        aq.push_back({10'h0AB, 1'b1});
        ch_req_address[1*ADDR_W +: ADDR_W] = 10'h0AB;
        ch_req_destructive = 4'b0010;
        ch_req_valid = 4'b0010;
        tick; ch_req_valid = '0;
        tick; blk(1, 64'hBEEF_0001, 4'd8, 1'b0, 1'b0);
        tick;
        pb_valid = 1'b1; pb_data = 64'hBEEF_0002; pb_is_last = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_rsp", 64'(ch_rsp_valid), 64'd0);
        check("rst_mid_enable", 64'(pb_enable), 64'd0);
        check("rst_mid_first", 64'(pb_is_first), 64'd0);
        check("rst_mid_addr", 64'(pb_address), 64'd0);
        check("rst_mid_destr", 64'(pb_is_destructive), 64'd0);
        check("rst_mid_err", 64'(rsp_error), 64'd0);
        pb_valid = 1'b0;
        tick; tick;
        reset_n = 1'b1;
        tick;
        gq.push_back(0);
        aq.push_back({10'h1C3, 1'b0});
        gq.push_back(1);
        aq.push_back({10'h0AB, 1'b1});
        ch_req_destructive = 4'b0010;
        ch_req_valid = 4'b0011;
        tick; ch_req_valid = 4'b0010;
        tick; blk(0, 64'hC0C0, 4'd1, 1'b1, 1'b0);
        tick; ch_req_valid = '0; pb_valid = 1'b0; pb_is_last = 1'b0;
        tick; blk(1, 64'hC1C1, 4'd7, 1'b1, 1'b0);
        tick; pb_valid = 1'b0; pb_is_last = 1'b0;
        tick; tick;

        check("gq_empty", 64'(gq.size()), 64'd0);
        check("aq_empty", 64'(aq.size()), 64'd0);
        check("rq_empty", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
